// File: rtl/seg7_pkg.sv
// Shared types and segment encoding for the divider result display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int OPND_W = 16;
  localparam int BCD_W  = 20;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Divider-side bus into the scanned display: result capture, mode selects,
// and the board-facing digit enables and segment lines.
interface seg7_scan_display_if;
  import seg7_pkg::*;

  logic              load;
  logic [OPND_W-1:0] quotient;
  logic [OPND_W-1:0] remainder;
  logic              sel;
  logic              dec;
  logic              blank_lz;
  logic              busy;
  logic              led1;
  logic              led2;
  logic              led3;
  logic              led4;
  logic [6:0]        out;

  modport master (
    output load, quotient, remainder, sel, dec, blank_lz,
    input  busy, led1, led2, led3, led4, out
  );

  modport slave (
    input  load, quotient, remainder, sel, dec, blank_lz,
    output busy, led1, led2, led3, led4, out
  );

endinterface

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, WIDTH steps total.
// A start while busy discards the current conversion and reloads.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bin_d = value_i;
      bcd_d = '0;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
      bin_d = {bin_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  // done marks the cycle whose edge performs the final step
  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CNT_W'(1)) && !start_i;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_scan_display.sv
// Latches divider results, converts the selected word to hex or BCD digits,
// and scans the four digits onto an active-low 7-segment bus.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int WIDTH       = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_display_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e           state_q;
  logic             busy_q;
  logic [WIDTH-1:0] quo_q, rem_q, val_q;
  logic             sel_q, dec_q;
  logic [15:0]      disp_q;
  logic             ovf_q;

  logic             trig;
  logic [WIDTH-1:0] src;
  logic             bcd_busy, bcd_done;
  logic [BCD_W-1:0] bcd;

  assign trig = bus.load || (bus.sel != sel_q) || (bus.dec != dec_q);

  // operands arriving this cycle win over the latched copies
  assign src = bus.sel ? (bus.load ? bus.remainder : rem_q)
                       : (bus.load ? bus.quotient  : quo_q);

  bin2bcd_seq #(.WIDTH(WIDTH)) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (trig && bus.dec),
    .value_i (src),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      val_q   <= '0;
      sel_q   <= 1'b0;
      dec_q   <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sel_q <= bus.sel;
      dec_q <= bus.dec;
      if (bus.load) begin
        quo_q <= bus.quotient;
        rem_q <= bus.remainder;
      end
      if (trig) begin
        val_q   <= src;
        state_q <= bus.dec ? CONV : COMMIT;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: busy_q <= 1'b0;
          CONV: if (bcd_done || !bcd_busy) state_q <= COMMIT;
          COMMIT: begin
            disp_q  <= dec_q ? bcd[15:0] : val_q;
            ovf_q   <= dec_q && (bcd[19:16] != 4'd0);
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic [3:0]    led_q, led_d;
  logic [6:0]    out_q, out_d;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic          wrap;

  always_comb begin
    wrap          = (refresh_cnt_q == CW'(REFRESH_DIV - 1));
    refresh_cnt_d = wrap ? '0 : refresh_cnt_q + CW'(1);
    digit_sel_d   = wrap ? digit_sel_q + 2'd1 : digit_sel_q;
    nib           = disp_q[{digit_sel_q, 2'b00} +: 4];
    // lz[k]: digit k and everything above it are zero; digit 0 always lit
    lz[3] = (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    lz[0] = 1'b0;
    led_d = 4'b0001 << digit_sel_q;
    if (ovf_q)                              out_d = SEG_DASH;
    else if (bus.blank_lz && lz[digit_sel_q]) out_d = SEG_BLANK;
    else                                    out_d = hex_to_seg(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= '0;
      led_q         <= '0;
      out_q         <= SEG_BLANK;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_sel_q   <= digit_sel_d;
      led_q         <= led_d;
      out_q         <= out_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.led1 = led_q[0];
  assign bus.led2 = led_q[1];
  assign bus.led3 = led_q[2];
  assign bus.led4 = led_q[3];
  assign bus.out  = out_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scenario bench for seg7_scan_display with a short refresh period; expected
// scan frames go into a queue when stimulus is applied and are popped per digit.
module tb_seg7_scan_display;
  import seg7_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_display_if bus();

  seg7_scan_display #(.REFRESH_DIV(4), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;
  logic [10:0] exp_q[$];
  logic [10:0] frame[16];
  bit          frame_ok;

  function automatic logic [3:0] leds();
    return {bus.led4, bus.led3, bus.led2, bus.led1};
  endfunction

  task automatic do_load(input logic [15:0] q, input logic [15:0] r);
    bus.quotient  = q;
    bus.remainder = r;
    bus.load      = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  // align to a fresh led1 rise and record one full 16-cycle scan
  task automatic capture_frame();
    logic [3:0] prev;
    frame_ok = 1'b0;
    @(negedge clk);
    prev = leds();
    for (int i = 0; i < 40 && !frame_ok; i++) begin
      @(negedge clk);
      if (leds() == 4'b0001 && prev != 4'b0001) frame_ok = 1'b1;
      else prev = leds();
    end
    if (frame_ok) begin
      frame[0] = {leds(), bus.out};
      for (int i = 1; i < 16; i++) begin
        @(negedge clk);
        frame[i] = {leds(), bus.out};
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (leds() !== 4'b0000) $display("FAIL reset_led: got %b expected 0000", leds());
    else passed++;
    total++;
    if (bus.out !== 7'b1111111) $display("FAIL reset_out: got %b expected 1111111", bus.out);
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (leds() !== 4'b0001) $display("FAIL release_led: got %b expected 0001", leds());
    else passed++;
    total++;
    if (bus.out !== 7'b1000000) $display("FAIL release_out: got %b expected 1000000", bus.out);
    else passed++;
  endtask

  task automatic test_hex_quotient();
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.dec = 1'b0; bus.blank_lz = 1'b0;
    do_load(16'd870, 16'd0);
    exp_q.push_back({4'b0001, 7'b0000010});
    exp_q.push_back({4'b0010, 7'b0000010});
    exp_q.push_back({4'b0100, 7'b0110000});
    exp_q.push_back({4'b1000, 7'b1000000});
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL hex_busy_n: got %b expected 1", bus.busy);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) $display("FAIL hex_busy_n1: got %b expected 0", bus.busy);
    else passed++;
    capture_frame();
    if (!frame_ok) begin
      total++;
      $display("FAIL hex_sync: led1 rise seen=0 expected 1");
      exp_q.delete();
    end else begin
      for (int d = 0; d < 4; d++) begin
        logic [10:0] e;
        e = exp_q.pop_front();
        for (int c = 0; c < 4; c++) begin
          total++;
          if (frame[d*4+c] !== e)
            $display("FAIL hex_digit%0d: got %b expected %b", d, frame[d*4+c], e);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_dec_remainder();
    int busy_cnt;
    @(posedge clk);
    #1;
    bus.sel = 1'b1; bus.dec = 1'b1; bus.blank_lz = 1'b1;
    do_load(16'd870, 16'd10);
    exp_q.push_back({4'b0001, 7'b1000000});
    exp_q.push_back({4'b0010, 7'b1111001});
    exp_q.push_back({4'b0100, 7'b1111111});
    exp_q.push_back({4'b1000, 7'b1111111});
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (k == 17) begin
        total++;
        if (bus.busy !== 1'b0) $display("FAIL dec_busy_low_n17: got %b expected 0", bus.busy);
        else passed++;
      end
    end
    total++;
    if (busy_cnt != 17) $display("FAIL dec_busy_cycles: got %0d expected 17", busy_cnt);
    else passed++;
    capture_frame();
    if (!frame_ok) begin
      total++;
      $display("FAIL dec_sync: led1 rise seen=0 expected 1");
      exp_q.delete();
    end else begin
      for (int d = 0; d < 4; d++) begin
        logic [10:0] e;
        e = exp_q.pop_front();
        for (int c = 0; c < 4; c++) begin
          total++;
          if (frame[d*4+c] !== e)
            $display("FAIL dec_digit%0d: got %b expected %b", d, frame[d*4+c], e);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_overflow();
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    do_load(16'd65535, 16'd3);
    for (int d = 0; d < 4; d++) exp_q.push_back({4'b0001 << d, 7'b0111111});
    repeat (20) @(negedge clk);
    capture_frame();
    if (!frame_ok) begin
      total++;
      $display("FAIL ovf_sync: led1 rise seen=0 expected 1");
      exp_q.delete();
    end else begin
      for (int d = 0; d < 4; d++) begin
        logic [10:0] e;
        e = exp_q.pop_front();
        for (int c = 0; c < 4; c++) begin
          total++;
          if (frame[d*4+c] !== e)
            $display("FAIL ovf_digit%0d: got %b expected %b", d, frame[d*4+c], e);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_restart();
    int first_low, early_change, leak;
    @(posedge clk);
    #1;
    do_load(16'd1234, 16'd0);
    repeat (7) @(posedge clk);
    #1;
    do_load(16'd42, 16'd0);
    exp_q.push_back({4'b0001, 7'b0100100});
    exp_q.push_back({4'b0010, 7'b0011001});
    exp_q.push_back({4'b0100, 7'b1111111});
    exp_q.push_back({4'b1000, 7'b1111111});
    first_low = -1; early_change = 0; leak = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (first_low < 0 && bus.busy === 1'b0) first_low = k;
      if (k <= 17 && bus.out !== 7'b0111111) early_change++;
      if (leds() == 4'b0001 && bus.out === 7'b0011001) leak++;
    end
    total++;
    if (first_low != 17) $display("FAIL restart_busy_low: got cycle %0d expected 17", first_low);
    else passed++;
    total++;
    if (early_change != 0) $display("FAIL restart_early_commit: got %0d changed samples expected 0", early_change);
    else passed++;
    total++;
    if (leak != 0) $display("FAIL restart_stale_1234: got %0d samples expected 0", leak);
    else passed++;
    capture_frame();
    if (!frame_ok) begin
      total++;
      $display("FAIL restart_sync: led1 rise seen=0 expected 1");
      exp_q.delete();
    end else begin
      for (int d = 0; d < 4; d++) begin
        logic [10:0] e;
        e = exp_q.pop_front();
        for (int c = 0; c < 4; c++) begin
          total++;
          if (frame[d*4+c] !== e)
            $display("FAIL restart_digit%0d: got %b expected %b", d, frame[d*4+c], e);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_reset_midconv();
    @(posedge clk);
    #1;
    do_load(16'd7, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.busy);
    else passed++;
    total++;
    if (leds() !== 4'b0000) $display("FAIL midrst_led: got %b expected 0000", leds());
    else passed++;
    total++;
    if (bus.out !== 7'b1111111) $display("FAIL midrst_out: got %b expected 1111111", bus.out);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (leds() !== 4'b0001) $display("FAIL midrst_release_led: got %b expected 0001", leds());
    else passed++;
    total++;
    if (bus.out !== 7'b1000000) $display("FAIL midrst_release_out: got %b expected 1000000", bus.out);
    else passed++;
    exp_q.push_back({4'b0001, 7'b1000000});
    exp_q.push_back({4'b0010, 7'b1111111});
    exp_q.push_back({4'b0100, 7'b1111111});
    exp_q.push_back({4'b1000, 7'b1111111});
    repeat (20) @(negedge clk);
    capture_frame();
    if (!frame_ok) begin
      total++;
      $display("FAIL midrst_sync: led1 rise seen=0 expected 1");
      exp_q.delete();
    end else begin
      for (int d = 0; d < 4; d++) begin
        logic [10:0] e;
        e = exp_q.pop_front();
        for (int c = 0; c < 4; c++) begin
          total++;
          if (frame[d*4+c] !== e)
            $display("FAIL midrst_digit%0d: got %b expected %b", d, frame[d*4+c], e);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst           = 1'b0;
    bus.load      = 1'b0;
    bus.quotient  = '0;
    bus.remainder = '0;
    bus.sel       = 1'b0;
    bus.dec       = 1'b0;
    bus.blank_lz  = 1'b0;
    test_reset();
    test_hex_quotient();
    test_dec_remainder();
    test_overflow();
    test_restart();
    test_reset_midconv();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Downstream consumer of the sequential 16-bit divider. Latches quotient and remainder when the divider pulses `done`. Converts the selected word to hex or decimal digits, using a sequential double-dabble for decimal. Time-multiplexes the four digits onto the board's active-low 7-segment bus with one-hot digit enables.

## Interface
- `REFRESH_DIV`, 50000, clock cycles each digit is displayed before advancing
- `WIDTH`, 16, operand width; only 16 is supported
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-low reset; the block is held in reset while `rst`=0
- `load`  in  1  single-cycle pulse (the divider's `done`); captures `quotient`/`remainder`
- `quotient`  in  16  divider quotient
- `remainder`  in  16  divider remainder
- `sel`  in  1  0 = show quotient, 1 = show remainder
- `dec`  in  1  0 = hex, 1 = decimal
- `blank_lz`  in  1  1 = blank leading zero digits (digit 0 always lit)
- `busy`  out  1  conversion in progress
- `led1`..`led4`  out  1 each  one-hot digit enables, active-high; `led1` = least-significant digit
- `out`  out  7  segments `{g,f,e,d,c,b,a}`, active-low

## Operation
- **Capture:** `load`=1 at edge N registers both operands.
- **Triggers:** `trig` = `load` OR `sel`≠`sel_q` OR `dec`≠`dec_q`. `sel_q`/`dec_q` are the values registered the previous cycle.
- **FSM `IDLE` / `CONV` / `COMMIT`:**
  - `trig` in any state → `CONV` if `dec`=1, else `COMMIT`. Conversion counter reloads to 16.
  - An in-flight conversion is discarded and restarted; the newest operands and mode always win.
  - `CONV`: one double-dabble step per cycle. First, add 3 to each BCD nibble ≥5. Then shift `{bcd[19:0], bin[15:0]}` left by 1. After 16 steps → `COMMIT`.
  - `COMMIT`: write the 4-nibble display register and the overflow flag, then → `IDLE`.
- **Hex commit:** nibbles = value[3:0], [7:4], [11:8], [15:12]. Overflow = 0.
- **Decimal commit:** nibbles = BCD digits 0..3. Overflow = 1 if BCD digit 4 ≠ 0 (value > 9999).
- **Overflow display:** all four digits show `-` (`out`=0111111), regardless of `blank_lz`.
- **Leading-zero blanking** (`blank_lz`=1, no overflow): a digit k>0 is blank (1111111) if it and every higher digit are 0.
- **Refresh:** `refresh_cnt` counts 0..`REFRESH_DIV`-1. At wrap, the 2-bit `digit_sel` increments 0→1→2→3→0.
- **Output register:** each cycle, `led` = onehot(`digit_sel`) and `out` = decode(display digit `digit_sel`). Segment codes 0–F match the existing divider board encoding.
- **Display register changes** only at `COMMIT`, so a displayed value never shows a partial conversion.
- **Reset values:**
  - `led1`..`led4`=0, `out`=1111111, `busy`=0
  - state `IDLE`, operands 0, display register 0, overflow 0
  - `refresh_cnt`=0, `digit_sel`=0, `sel_q`/`dec_q` = 0
- **Power-up mode:** if `sel` or `dec` is 1 at reset release, the first cycle after release sees a trigger and converts operands 0.

## Timing
- **Decimal:** `load` at edge N → `busy`=1 after edges N..N+16, `COMMIT` at edge N+17 (`busy` low after it). New value is on `out` at edge N+18 for the current digit.
- **Hex:** `COMMIT` at edge N+1, visible at edge N+2.
- **Restart:** `trig` during `CONV` at edge M → completion at M+17.
- **Scan:** each digit is held exactly `REFRESH_DIV` cycles. The scan is never stalled by conversion or triggers.
- **Reset mid-conversion:** the conversion is abandoned and the display register returns to 0. The first non-reset edge drives `led1`=1 with digit 0.

## Structure
- **Package `seg7_pkg`:**
  - constants `SEG_BLANK`=1111111, `SEG_DASH`=0111111
  - function `hex_to_seg(4b)` returning 7b
  - localparam state encoding `IDLE`/`CONV`/`COMMIT`
- **Sub-module `bin2bcd_seq`:** start/busy/done handshake, 16-cycle double-dabble, 20-bit BCD out. The top owns the FSM, scan counter and output decode.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles → `led1`..`led4`=0, `out`=1111111, `busy`=0. Release → `led1`=1, `out`=1000000.
- **Hex quotient:** `load` with quotient=870 (32200/37), `sel`=0, `dec`=0, `REFRESH_DIV`=4 → digits 6,6,3,0 (0000010, 0000010, 0110000, 1000000), each held 4 cycles. `busy` is high only for edge N..N+1.
- **Decimal remainder:** `load` quotient=870, remainder=10, `dec`=1, `sel`=1, `blank_lz`=1 → `busy` high 17 cycles. Digits 0,1 on `led1`/`led2`, `led3`/`led4` blank.
- **Decimal overflow:** `load` quotient=65535, `dec`=1 → all digits 0111111.
- **Restart:** `load` 1234 decimal, then `load` 42 at N+8 → only "42" is ever committed, at N+25. 1234 never appears.
- **Reset mid-conversion:** `rst`=0 at N+5 → `busy`=0, display 0, scan restarts at `led1`.
